hazard_unit: RTL
================

# hazard_unit

- Parametrised hazard and pipeline-control unit for the 5-stage core (IF, ID, EX, MEM, WB).
- Keeps its own shadow pipeline of destination-register tags for the in-flight post-decode stages.
- Each cycle it generates front-end hold, bubble/flush and operand-forward selects, replacing the current unprotected pipeline.
- Sits beside the decode stage; the top level wires its outputs to the fetch stage, the IF/ID and ID/EX registers and the EX operand muxes.

## Interface
Parameters:
- REG_ADDR_W, 5: register index width.
- STALL_CNT_W, 16: width of the saturating stall counter.

Ports (reset is asynchronous, active-low):
- clk  input  1  core clock.
- reset  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs1, id_rs2  input  REG_ADDR_W  source indices in ID.
- id_use_rs1, id_use_rs2  input  1  the instruction actually reads that source.
- id_rd  input  REG_ADDR_W  destination index in ID.
- id_wr  input  1  the instruction writes id_rd.
- id_load  input  1  the instruction is a load.
- ex_redirect  input  1  a taken branch or jump was resolved in EX this cycle.
- ext_stall  input  1  memory busy; freezes the whole pipe.
- pc_hold  output  1  fetch keeps its PC.
- ifid_hold  output  1  the IF/ID register keeps its contents.
- ifid_flush  output  1  the IF/ID register loads a bubble.
- idex_bubble  output  1  the ID/EX register loads a bubble (control bits cleared).
- fwd_rs1, fwd_rs2  output  2  registered EX operand select: 0 = ID/EX value, 1 = MEM-stage ALU result, 2 = WB data.
- stall_cnt  output  STALL_CNT_W  count of hazard-stall cycles.

## Operation
- Shadow pipeline has three slots: S0 = EX, S1 = MEM, S2 = WB. Each slot holds {valid, rd, load}.
- A producer matches a source when all of these hold: slot valid, rd == source, rd != 0, and the matching id_use_* is set.
- Dependences on S2 need no forwarding: the register file is write-through.
- Load-use hazard: id_valid and S0 is a load that matches either source.
- Stall condition (`hz`), with forwarding compiled in: the load-use hazard only.
- On `hz`:
  - pc_hold = ifid_hold = idex_bubble = 1.
  - The bubble enters S0; S0 moves to S1 and S1 to S2.
- Forward selects, computed in ID and registered into fwd_rs* when ID advances to EX:
  - S0 match gives 1; otherwise an S1 match gives 2; otherwise 0.
  - The youngest producer wins.
- Redirect: when ex_redirect = 1 and ext_stall = 0:
  - ifid_flush = idex_bubble = 1 and pc_hold = 0.
  - The bubble enters S0; fwd_rs* are cleared.
- Redirect overrides `hz`: the stalled instruction is on the wrong path.
- ext_stall = 1:
  - All slots and fwd_rs* hold their values.
  - pc_hold = ifid_hold = 1; ifid_flush = idex_bubble = 0.
  - A pending redirect is acted on in the first cycle after ext_stall falls. EX is frozen, so ex_redirect stays asserted until then.
- Normal advance (no stall, no redirect):
  - S0 <= {id_valid & id_wr, id_rd, id_load}.
  - S1 <= S0 and S2 <= S1.
- stall_cnt increments on every cycle where `hz` causes a stall and there is no redirect or ext_stall. It saturates at all-ones.

## Timing
- pc_hold, ifid_hold, ifid_flush and idex_bubble are combinational from ID inputs and slot state, and are valid in the same cycle.
- fwd_rs* and the slots update on posedge clk; the selects are used by EX in the following cycle.
- Load-use costs exactly 1 bubble. The consumer then sees fwd = 2.
- Redirect costs 2 bubbles: the IF/ID and ID/EX contents.
- On reset assertion, regardless of clk:
  - All slots become invalid.
  - fwd_rs1 = fwd_rs2 = 0 and stall_cnt = 0.
  - All hold/flush outputs are 0.
- On reset mid-stall, the unit restarts with no hazards pending.

## Configuration
- FORWARDING_EN defined: behaviour is as above.
- FORWARDING_EN undefined:
  - fwd_rs* are tied to 0.
  - `hz` = id_valid and either source matches S0 or S1, regardless of load.
  - A dependent instruction stalls until its producer reaches WB: up to 2 bubbles for an ALU producer as well as for a load.

## Structure
- hazard_pkg holds:
  - The FWD_NONE, FWD_MEM and FWD_WB encodings (0, 1, 2).
  - The slot tag layout (valid, rd, load) and the slot count constant NUM_SLOTS = 3.
- Sub-module dest_tag_pipe implements the shift/hold/bubble behaviour of the three tag slots. hazard_unit instantiates it and adds the match logic, stall/flush logic and stall counter.

## Test plan
- Back-to-back ALU ops: `add x5` then `sub x6,x5,x1` → no stall; consumer in EX sees fwd_rs1 = 1.
- One unrelated op between producer and consumer, `x5` producer → fwd_rs1 = 2, no stall.
- Load-use: `lw x7` then `add x8,x7,x7` → exactly 1 cycle with pc_hold = ifid_hold = idex_bubble = 1; then fwd_rs1 = fwd_rs2 = 2; stall_cnt = 1.
- Destination x0: producer writes x0 and consumer reads x0 → no stall; fwd = 0.
- ex_redirect in the same cycle as a load-use hazard → ifid_flush = idex_bubble = 1, pc_hold = 0; stall_cnt unchanged.
- ext_stall for 3 cycles with a redirect pending:
  - Slots and fwd frozen throughout.
  - The flush occurs in the cycle after release.
  - Then assert reset mid-stream → all outputs return to 0 immediately.
- FORWARDING_EN undefined: back-to-back `add x5` then `sub x6,x5,x1` → 2 stall cycles; fwd_rs1 stays 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard / pipeline-control unit:
//   - operand-forward select encodings driven to the EX operand muxes
//   - shadow tag slot layout {valid, rd, load} and slot indices
//   - command encoding for the destination-tag shift register
// ----------------------------------------------------------------------------
package hazard_pkg;

    // EX operand select: ID/EX value, MEM-stage ALU result, WB data.
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    // Shadow pipeline slots: one per post-decode stage.
    localparam int NUM_SLOTS = 3;
    localparam int SLOT_EX   = 0;
    localparam int SLOT_MEM  = 1;
    localparam int SLOT_WB   = 2;

    // Tag layout, MSB to LSB: {valid, rd[rd_w-1:0], load}.
    localparam int TAG_LOAD_BIT = 0;
    localparam int TAG_RD_LSB   = 1;

    function automatic int tag_w(input int rd_w);
        return rd_w + 2;
    endfunction

    // What the tag pipe does on the next clock edge.
    typedef enum logic [1:0] {
        TAG_SHIFT  = 2'd0,  // ID tag enters EX, everything advances
        TAG_HOLD   = 2'd1,  // whole pipe frozen
        TAG_BUBBLE = 2'd2   // empty tag enters EX, everything else advances
    } tag_cmd_e;

endpackage

// File: rtl/dest_tag_pipe.sv
// ----------------------------------------------------------------------------
// dest_tag_pipe
// Three-slot shadow shift register of destination tags (EX, MEM, WB) kept in
// step with the real pipeline. Each slot is {valid, rd, load}.
//
// Ports:
//   clk_i     core clock
//   rst_n_i   asynchronous active-low reset; empties every slot
//   cmd_i     tag_cmd_e: shift in tag_i / hold all / shift in a bubble
//   tag_i     tag of the instruction currently in ID
//   tags_o    all slots, slot i at [i*TW +: TW] (slot 0 = EX)
// ----------------------------------------------------------------------------
module dest_tag_pipe
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                                    clk_i,
    input  logic                                    rst_n_i,
    input  logic [1:0]                              cmd_i,
    input  logic [tag_w(REG_ADDR_W)-1:0]            tag_i,
    output logic [NUM_SLOTS*tag_w(REG_ADDR_W)-1:0]  tags_o
);

    localparam int TW = tag_w(REG_ADDR_W);

    logic [TW-1:0] slot_q [NUM_SLOTS];
    logic [TW-1:0] slot_d [NUM_SLOTS];

    always_comb begin
        slot_d = slot_q;
        case (tag_cmd_e'(cmd_i))
            TAG_SHIFT: begin
                slot_d[0] = tag_i;
                for (int i = 1; i < NUM_SLOTS; i++) slot_d[i] = slot_q[i-1];
            end
            TAG_BUBBLE: begin
                slot_d[0] = '0;
                for (int i = 1; i < NUM_SLOTS; i++) slot_d[i] = slot_q[i-1];
            end
            default: ;  // TAG_HOLD: keep everything
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
        assign tags_o[g*TW +: TW] = slot_q[g];
    end

endmodule

// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
// Hazard detection and pipeline control for the 5-stage core. Tracks the
// destination tags of the instructions in EX/MEM/WB, and each cycle decides
// whether the front end holds, which pipeline registers take a bubble, and
// which operand source EX uses next cycle.
//
// Build option: define FORWARDING_EN to enable EX operand forwarding. Without
// it, fwd_rs1/fwd_rs2 are tied to 0 and any dependence on EX or MEM stalls
// until the producer reaches WB.
//
// Ports:
//   clk, reset (async, active-low)
//   id_valid, id_rs1/2, id_use_rs1/2, id_rd, id_wr, id_load : ID instruction
//   ex_redirect  taken branch/jump resolved in EX
//   ext_stall    memory busy, freezes the whole pipe
//   pc_hold, ifid_hold, ifid_flush, idex_bubble : combinational controls
//   fwd_rs1, fwd_rs2  registered EX operand selects (fwd_sel_e)
//   stall_cnt         saturating count of hazard-stall cycles
// ----------------------------------------------------------------------------
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_wr,
    input  logic                   id_load,
    input  logic                   ex_redirect,
    input  logic                   ext_stall,
    output logic                   pc_hold,
    output logic                   ifid_hold,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic [1:0]             fwd_rs1,
    output logic [1:0]             fwd_rs2,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int TW = tag_w(REG_ADDR_W);

    logic [NUM_SLOTS*TW-1:0] tags;
    logic [TW-1:0]           s_ex, s_mem, s_wb;
    tag_cmd_e                tag_cmd;

    dest_tag_pipe #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_tags (
        .clk_i   (clk),
        .rst_n_i (reset),
        .cmd_i   (tag_cmd),
        .tag_i   ({id_valid & id_wr, id_rd, id_load}),
        .tags_o  (tags)
    );

    assign s_ex  = tags[SLOT_EX*TW  +: TW];
    assign s_mem = tags[SLOT_MEM*TW +: TW];
    assign s_wb  = tags[SLOT_WB*TW  +: TW];

    // The register file is write-through, so a producer in WB never needs
    // forwarding or a stall; its tag is tracked only to keep the shadow
    // pipeline the same depth as the real one.
    logic unused_wb_tag;
    assign unused_wb_tag = ^s_wb;

    // A slot produces a source when it is live, writes that register, the
    // register is not x0, and ID actually reads the source.
    function automatic logic produces(input logic [TW-1:0] tag,
                                      input logic [REG_ADDR_W-1:0] src,
                                      input logic use_src);
        logic [REG_ADDR_W-1:0] rd;
        rd = tag[TW-2:TAG_RD_LSB];
        return tag[TW-1] && use_src && (rd == src) && (rd != '0);
    endfunction

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic ex_rs1, ex_rs2, mem_rs1, mem_rs2;
    logic load_use, hz;

    assign ex_rs1  = produces(s_ex,  id_rs1, id_use_rs1);
    assign ex_rs2  = produces(s_ex,  id_rs2, id_use_rs2);
    assign mem_rs1 = produces(s_mem, id_rs1, id_use_rs1);
    assign mem_rs2 = produces(s_mem, id_rs2, id_use_rs2);

    assign load_use = id_valid & s_ex[TAG_LOAD_BIT] & (ex_rs1 | ex_rs2);

`ifdef FORWARDING_EN
    // Only a load in EX cannot be forwarded in time.
    assign hz = load_use;
`else
    // Without forwarding every EX/MEM dependence waits for WB; load_use is a
    // subset of the EX term and is kept only for clarity.
    assign hz = load_use | (id_valid & (ex_rs1 | ex_rs2 | mem_rs1 | mem_rs2));
`endif

    logic fwd_clr, fwd_load, cnt_inc;

    // Priority: reset, then ext_stall (freeze), then redirect (wrong-path ID
    // instruction is discarded, so it overrides any hazard), then hazard.
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        tag_cmd     = TAG_SHIFT;
        fwd_clr     = 1'b0;
        fwd_load    = 1'b0;
        cnt_inc     = 1'b0;
        if (!reset) begin
            tag_cmd = TAG_HOLD;
        end else if (ext_stall) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            tag_cmd   = TAG_HOLD;
        end else if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            tag_cmd     = TAG_BUBBLE;
            fwd_clr     = 1'b1;
        end else if (hz) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            tag_cmd     = TAG_BUBBLE;
            fwd_clr     = 1'b1;
            cnt_inc     = 1'b1;
        end else begin
            fwd_load = 1'b1;
        end
    end

    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = cnt_inc ? sat_inc(stall_cnt_q) : stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

`ifdef FORWARDING_EN
    // Youngest producer wins: EX (moving to MEM) beats MEM (moving to WB).
    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit)  return FWD_MEM;
        if (mem_hit) return FWD_WB;
        return FWD_NONE;
    endfunction

    logic [1:0] fwd_rs1_q, fwd_rs1_d, fwd_rs2_q, fwd_rs2_d;

    always_comb begin
        fwd_rs1_d = fwd_rs1_q;
        fwd_rs2_d = fwd_rs2_q;
        if (fwd_clr) begin
            fwd_rs1_d = FWD_NONE;
            fwd_rs2_d = FWD_NONE;
        end else if (fwd_load) begin
            fwd_rs1_d = id_valid ? fwd_pick(ex_rs1, mem_rs1) : FWD_NONE;
            fwd_rs2_d = id_valid ? fwd_pick(ex_rs2, mem_rs2) : FWD_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_rs1_q <= FWD_NONE;
            fwd_rs2_q <= FWD_NONE;
        end else begin
            fwd_rs1_q <= fwd_rs1_d;
            fwd_rs2_q <= fwd_rs2_d;
        end
    end

    assign fwd_rs1 = fwd_rs1_q;
    assign fwd_rs2 = fwd_rs2_q;
`else
    logic unused_fwd_ctl;
    assign unused_fwd_ctl = fwd_clr ^ fwd_load;

    assign fwd_rs1 = FWD_NONE;
    assign fwd_rs2 = FWD_NONE;
`endif

endmodule
